// File: rtl/vga_fb_if.sv
// Bundle between vga_controller/host/RAM and the framebuffer arbiter.
// slave is the arbiter side; master is the surrounding system.
interface vga_fb_if #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              disp_ena;
   logic [10:0]       row;
   logic [10:0]       column;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic [LVL_W-1:0]  fifo_level;
   logic [15:0]       stall_cnt;

   modport slave (
      input  disp_ena, row, column,
      input  wr_valid, wr_addr, wr_data,
      input  mem_rdata,
      output wr_ready,
      output mem_addr, mem_we, mem_wdata,
      output pix_data, pix_valid,
      output fifo_level, stall_cnt
   );

   modport master (
      output disp_ena, row, column,
      output wr_valid, wr_addr, wr_data,
      output mem_rdata,
      input  wr_ready,
      input  mem_addr, mem_we, mem_wdata,
      input  pix_data, pix_valid,
      input  fifo_level, stall_cnt
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display owns the RAM in active video,
// buffered host writes drain during blanking.
module vga_fb_arbiter #(
   parameter int H_RES      = 640,
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 16
) (
   input logic    pixel_clk,
   input logic    rst,
   vga_fb_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

   logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level, level_d;
   logic              wr_ready_q, wr_ready_d;
   logic              pix_valid_q, pix_valid_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;

   logic              push, drain;
   logic [ADDR_W-1:0] disp_addr, head_addr;
   logic [DATA_W-1:0] head_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;

   // Pointers carry one extra bit so full and empty differ.
   assign level     = wr_ptr_q - rd_ptr_q;
   assign head_addr = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
   assign head_data = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
   assign disp_addr = ADDR_W'(bus.row) * ADDR_W'(H_RES)
                    + ADDR_W'(bus.column);

   assign drain = !bus.disp_ena && (level != '0);
   assign push  = bus.wr_valid && wr_ready_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q + LVL_W'(push);
      rd_ptr_d    = rd_ptr_q + LVL_W'(drain);
      level_d     = wr_ptr_d - rd_ptr_d;
      wr_ready_d  = level_d < FULL;
      pix_valid_d = bus.disp_ena;
      last_addr_d = last_addr_q;
      stall_cnt_d = stall_cnt_q;
      if (bus.disp_ena) begin
         last_addr_d = disp_addr;
      end else if (drain) begin
         last_addr_d = head_addr;
      end
      if (bus.wr_valid && !wr_ready_q && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Bus outputs are gated by rst so an in-flight write dies immediately.
   always_comb begin
      mem_addr  = last_addr_q;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (rst) begin
         mem_addr = '0;
      end else if (bus.disp_ena) begin
         mem_addr = disp_addr;
      end else if (drain) begin
         mem_addr  = head_addr;
         mem_we    = 1'b1;
         mem_wdata = head_data;
      end
   end

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         wr_ready_q  <= 1'b0;
         pix_valid_q <= 1'b0;
         last_addr_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ready_q  <= wr_ready_d;
         pix_valid_q <= pix_valid_d;
         last_addr_q <= last_addr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= bus.wr_addr;
         fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= bus.wr_data;
      end
   end

   assign bus.mem_addr   = mem_addr;
   assign bus.mem_we     = mem_we;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.wr_ready   = wr_ready_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.pix_data   = pix_valid_q ? bus.mem_rdata : '0;
   assign bus.fifo_level = level;
   assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter; host writes are queued as expected
// RAM writes and checked in order when mem_we is seen.
module tb_vga_fb_arbiter;
   localparam int AW = 19;
   localparam int DW = 24;
   localparam int D  = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   n_wr  = 0;
   int   snap;
   logic [AW+DW-1:0] exp_q[$];
   logic [AW+DW-1:0] mon_e;
   logic [AW-1:0]    last_a;

   vga_fb_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) bus();

   vga_fb_arbiter #(
      .H_RES(640), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)
   ) dut (
      .pixel_clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      exp_q.push_back({a, d});
      @(negedge clk);
      chk("push_rdy", 64'(bus.wr_ready), 64'd1);
      tick();
   endtask

   // Every RAM write must match the oldest accepted host write.
   always @(negedge clk) begin
      if (!rst && bus.mem_we === 1'b1) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexp_wr observed addr=%0h expected no write",
                   bus.mem_addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 64'(bus.mem_addr), 64'(mon_e[AW+DW-1:DW]));
            chk("wr_data", 64'(bus.mem_wdata), 64'(mon_e[DW-1:0]));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      bus.disp_ena  = 1'b1;
      bus.row       = 11'd3;
      bus.column    = 11'd7;
      bus.wr_valid  = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.mem_rdata = 24'hABCDEF;

      // 1: reset while display active
      #2 rst = 1'b1;
      #1;
      chk("rst_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_we", 64'(bus.mem_we), 64'd0);
      chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_pixd", 64'(bus.pix_data), 64'd0);
      chk("rst_pixv", 64'(bus.pix_valid), 64'd0);
      chk("rst_lvl", 64'(bus.fifo_level), 64'd0);
      chk("rst_stall", 64'(bus.stall_cnt), 64'd0);
      chk("rst_rdy", 64'(bus.wr_ready), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      bus.disp_ena = 1'b0;
      @(negedge clk);
      chk("rdy_rel0", 64'(bus.wr_ready), 64'd0);
      tick();
      @(negedge clk);
      chk("rdy_rel1", 64'(bus.wr_ready), 64'd1);
      tick();

      // 2: display address and one-cycle pixel latency
      bus.disp_ena = 1'b1;
      bus.row      = 11'd2;
      bus.column   = 11'd5;
      @(negedge clk);
      chk("disp_addr", 64'(bus.mem_addr), 64'd1285);
      chk("disp_we", 64'(bus.mem_we), 64'd0);
      tick();
      bus.mem_rdata = 24'h123456;
      bus.disp_ena  = 1'b0;
      @(negedge clk);
      chk("pix_valid", 64'(bus.pix_valid), 64'd1);
      chk("pix_data", 64'(bus.pix_data), 64'h123456);
      chk("idle_hold", 64'(bus.mem_addr), 64'd1285);
      tick();
      @(negedge clk);
      chk("pix_blank_v", 64'(bus.pix_valid), 64'd0);
      chk("pix_blank_d", 64'(bus.pix_data), 64'd0);
      tick();
      bus.disp_ena = 1'b1;
      bus.row      = 11'd479;
      bus.column   = 11'd639;
      @(negedge clk);
      chk("disp_addr_max", 64'(bus.mem_addr), 64'd307199);
      tick();

      // 3: three writes buffered during video, drained in blanking
      snap = n_wr;
      for (int i = 0; i < 3; i++) begin
         last_a = AW'(1000 + 7 * i);
         push(last_a, DW'(24'h110000 + i));
      end
      bus.wr_valid = 1'b0;
      @(negedge clk);
      chk("buf_lvl", 64'(bus.fifo_level), 64'd3);
      chk("buf_we", 64'(bus.mem_we), 64'd0);
      tick();
      bus.disp_ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("drain_we", 64'(bus.mem_we), 64'd1);
         tick();
      end
      @(negedge clk);
      chk("drain_cnt", 64'(n_wr - snap), 64'd3);
      chk("drain_lvl", 64'(bus.fifo_level), 64'd0);
      chk("drain_idle_we", 64'(bus.mem_we), 64'd0);
      chk("drain_hold", 64'(bus.mem_addr), 64'(last_a));
      tick();

      // push into empty FIFO during blanking: no fall-through
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(4242);
      bus.wr_data  = 24'h5A5A5A;
      exp_q.push_back({bus.wr_addr, bus.wr_data});
      @(negedge clk);
      chk("nofall_we", 64'(bus.mem_we), 64'd0);
      tick();
      bus.wr_valid = 1'b0;
      @(negedge clk);
      chk("nofall_we1", 64'(bus.mem_we), 64'd1);
      tick();

      // 4: fill to full, stall counting, refused push at full with pop
      bus.disp_ena = 1'b1;
      for (int i = 0; i < D; i++) begin
         push(AW'(20000 + 3 * i), DW'(24'h220000 + i));
      end
      bus.wr_addr = AW'(77);
      bus.wr_data = 24'hDEAD00;
      @(negedge clk);
      chk("full_rdy", 64'(bus.wr_ready), 64'd0);
      chk("full_lvl", 64'(bus.fifo_level), 64'd16);
      chk("full_stall0", 64'(bus.stall_cnt), 64'd0);
      tick();
      tick();
      tick();
      @(negedge clk);
      chk("full_stall3", 64'(bus.stall_cnt), 64'd3);
      bus.disp_ena = 1'b0;
      #1;
      chk("full_pop_rdy", 64'(bus.wr_ready), 64'd0);
      tick();
      bus.wr_valid = 1'b0;
      @(negedge clk);
      chk("full_lvl15", 64'(bus.fifo_level), 64'd15);
      chk("full_rdy15", 64'(bus.wr_ready), 64'd1);
      chk("full_stall4", 64'(bus.stall_cnt), 64'd4);
      for (int i = 0; i < 15; i++) tick();
      @(negedge clk);
      chk("full_empty", 64'(bus.fifo_level), 64'd0);
      tick();

      // 5: drain interrupted by active video
      bus.disp_ena = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push(AW'(30000 + 11 * i), DW'(24'h330000 + i));
      end
      bus.wr_valid = 1'b0;
      snap = n_wr;
      bus.disp_ena = 1'b0;
      tick();
      tick();
      tick();
      bus.disp_ena = 1'b1;
      @(negedge clk);
      chk("intr_we", 64'(bus.mem_we), 64'd0);
      chk("intr_cnt", 64'(n_wr - snap), 64'd3);
      chk("intr_lvl", 64'(bus.fifo_level), 64'd5);
      tick();
      tick();
      bus.disp_ena = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      chk("intr_cnt8", 64'(n_wr - snap), 64'd8);
      chk("intr_lvl0", 64'(bus.fifo_level), 64'd0);
      tick();

      // 6: push and pop each cycle hold the level
      bus.disp_ena = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(AW'(40000 + i), DW'(24'h440000 + i));
      end
      bus.disp_ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = AW'(41000 + 5 * i);
         bus.wr_data  = DW'(24'h450000 + i);
         exp_q.push_back({bus.wr_addr, bus.wr_data});
         @(negedge clk);
         chk("sim_lvl", 64'(bus.fifo_level), 64'd4);
         chk("sim_rdy", 64'(bus.wr_ready), 64'd1);
         tick();
      end
      bus.wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      @(negedge clk);
      chk("sim_lvl0", 64'(bus.fifo_level), 64'd0);
      tick();

      // reset in the middle of a drain
      bus.disp_ena = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(AW'(50000 + i), DW'(24'h550000 + i));
      end
      bus.wr_valid = 1'b0;
      bus.disp_ena = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mrst_we", 64'(bus.mem_we), 64'd0);
      chk("mrst_addr", 64'(bus.mem_addr), 64'd0);
      chk("mrst_lvl", 64'(bus.fifo_level), 64'd0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_rdy0", 64'(bus.wr_ready), 64'd0);
      tick();
      @(negedge clk);
      chk("mrst_rdy1", 64'(bus.wr_ready), 64'd1);
      chk("mrst_nowr", 64'(bus.mem_we), 64'd0);
      chk("mrst_stall", 64'(bus.stall_cnt), 64'd0);
      tick();

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
